// File: rtl/servo_pkg.sv
// Shared widths, default timing/range constants, FSM encoding and the
// position-to-pulsewidth mapping for the servo slew controller.
package servo_pkg;

    localparam int PW_W         = 12;
    localparam int POS_W        = 8;
    localparam int PERIOD_DEF   = 2000;
    localparam int MIN_PW_DEF   = 100;
    localparam int PW_RANGE_DEF = 100;
    localparam int STEP_DEF     = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_t;

    // Out-of-range positions saturate at the top of the legal range.
    function automatic logic [PW_W-1:0] pos_to_pw(
        input logic [POS_W-1:0] pos,
        input int               min_pw,
        input int               pw_range
    );
        logic [PW_W-1:0] offset;
        offset = {{(PW_W-POS_W){1'b0}}, pos};
        if (int'(pos) > pw_range) begin
            offset = PW_W'(pw_range);
        end
        return PW_W'(min_pw) + offset;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter that advances only while enabled and flags the
// last cycle of every frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic frame_tick
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] count;

    assign frame_tick = en && (count == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= frame_tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo command stage: latches a position command and ramps pulsewidth toward
// it by at most STEP per frame. SERVO_SLEW_CTRL_RANGE_ERR_EN enables sticky err.
//
//   state  | meaning
//   IDLE   | pulsewidth == target, accepting commands while en
//   MOVING | stepping pulsewidth toward target on each frame_tick
module servo_slew_ctrl
    import servo_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,
    parameter int MIN_PW   = MIN_PW_DEF,
    parameter int PW_RANGE = PW_RANGE_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_pos,
    output logic [PW_W-1:0]  pulsewidth,
    output logic             frame_tick,
    output logic             at_target,
    output logic             err
);

    localparam logic [PW_W-1:0] CENTER = PW_W'(MIN_PW + PW_RANGE / 2);
    localparam logic [PW_W-1:0] STEP_PW = PW_W'(STEP);

    state_t          state;
    state_t          state_nxt;
    logic [PW_W-1:0] target;
    logic [PW_W-1:0] cmd_pw;
    logic [PW_W-1:0] diff;
    logic [PW_W-1:0] step_pw;
    logic            close;
    logic            hs;

    servo_frame_timer #(
        .PERIOD(PERIOD)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .frame_tick(frame_tick)
    );

    assign hs     = cmd_valid && cmd_ready;
    assign cmd_pw = pos_to_pw(cmd_pos, MIN_PW, PW_RANGE);

    // Both operands stay inside [MIN_PW, MIN_PW+PW_RANGE], so no wrap here.
    assign diff    = (target >= pulsewidth) ? (target - pulsewidth) : (pulsewidth - target);
    assign close   = (diff <= STEP_PW);
    assign step_pw = close                 ? target :
                     (target > pulsewidth) ? pulsewidth + STEP_PW :
                                             pulsewidth - STEP_PW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs && (cmd_pw != pulsewidth)) begin
                    state_nxt = MOVING;
                end
            end
            MOVING: begin
                if (frame_tick && close) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        at_target = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = en;
                at_target = 1'b1;
            end
            MOVING: begin
                cmd_ready = 1'b0;
                at_target = 1'b0;
            end
            default: begin
                cmd_ready = 1'b0;
                at_target = 1'b0;
            end
        endcase
    end

    // frame_tick and hs are already gated by en, so en=0 freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target     <= CENTER;
            pulsewidth <= CENTER;
        end else begin
            if (hs) begin
                target <= cmd_pw;
            end
            if ((state == MOVING) && frame_tick) begin
                pulsewidth <= step_pw;
            end
        end
    end

`ifdef SERVO_SLEW_CTRL_RANGE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (hs && (int'(cmd_pos) > PW_RANGE)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Self-checking bench for servo_slew_ctrl: directed ramps plus randomized
// small moves, compared against a frame-level arithmetic model.
module tb_servo_slew_ctrl;

    localparam int PERIOD   = 2000;
    localparam int MIN_PW   = 100;
    localparam int PW_RANGE = 100;
    localparam int STEP     = 5;
    localparam int CENTER   = MIN_PW + PW_RANGE / 2;
`ifdef SERVO_SLEW_CTRL_RANGE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_pos;
    logic [11:0] pulsewidth;
    logic        frame_tick;
    logic        at_target;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;
    int pw_m    = CENTER;
    bit err_m   = 1'b0;
    int en_cycles = 0;

    servo_slew_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_pos   (cmd_pos),
        .pulsewidth(pulsewidth),
        .frame_tick(frame_tick),
        .at_target (at_target),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enabled cycles since reset; a frame ends every PERIOD of them.
    always @(posedge clk or posedge rst) begin
        if (rst) en_cycles <= 0;
        else if (en) en_cycles <= en_cycles + 1;
    end

    always @(negedge clk) begin
        bit exp_tick;
        #1;
        exp_tick = en && ((en_cycles % PERIOD) == PERIOD - 1);
        n_total++;
        if (frame_tick !== exp_tick)
            $display("FAIL frame_tick_timing t=%0t got=%b exp=%b", $time, frame_tick, exp_tick);
        else
            n_pass++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pw_m  = CENTER;
        err_m = 1'b0;
    endtask

    // Waits for frame_tick, checking pulsewidth is held in between.
    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) return;
            n_total++;
            if (pulsewidth !== 12'(pw_m))
                $display("FAIL pw_held_between_ticks got=%0d exp=%0d", pulsewidth, pw_m);
            else
                n_pass++;
            if (n > PERIOD + 5) begin
                n_total++;
                $display("FAIL tick_timeout waited=%0d exp<=%0d", n, PERIOD);
                return;
            end
        end
    endtask

    task automatic do_cmd(input int pos, input bit align);
        int tgt;
        int n;
        int p;
        int steps[$];
        bit last;
        @(negedge clk);
        if (align) begin
            n = 0;
            while (frame_tick !== 1'b1 && n <= PERIOD + 5) begin
                @(negedge clk);
                n++;
            end
            n_total++;
            if (frame_tick !== 1'b1) $display("FAIL align_tick got=%b exp=1", frame_tick);
            else n_pass++;
        end
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_before_cmd got=%b exp=1", cmd_ready);
        else n_pass++;
        cmd_pos   = 8'(pos);
        cmd_valid = 1'b1;
        @(negedge clk);
        tgt = MIN_PW + ((pos > PW_RANGE) ? PW_RANGE : pos);
        if (pos > PW_RANGE && ERR_ON) err_m = 1'b1;
        p = pw_m;
        while (p != tgt) begin
            if (tgt - p > STEP) p += STEP;
            else if (p - tgt > STEP) p -= STEP;
            else p = tgt;
            steps.push_back(p);
        end
        if (steps.size() == 0) cmd_valid = 1'b0;
        else cmd_pos = 8'($urandom_range(0, PW_RANGE));
        n_total++;
        if (pulsewidth !== 12'(pw_m)) $display("FAIL pw_after_hs got=%0d exp=%0d", pulsewidth, pw_m);
        else n_pass++;
        n_total++;
        if (cmd_ready !== (steps.size() == 0)) $display("FAIL ready_after_hs got=%b exp=%b", cmd_ready, steps.size() == 0);
        else n_pass++;
        n_total++;
        if (at_target !== (steps.size() == 0)) $display("FAIL at_target_after_hs got=%b exp=%b", at_target, steps.size() == 0);
        else n_pass++;
        n_total++;
        if (err !== err_m) $display("FAIL err_after_hs got=%b exp=%b", err, err_m);
        else n_pass++;
        foreach (steps[i]) begin
            wait_tick(n);
            @(negedge clk);
            pw_m = steps[i];
            last = (i == steps.size() - 1);
            if (last) cmd_valid = 1'b0;
            n_total++;
            if (pulsewidth !== 12'(pw_m)) $display("FAIL ramp_step idx=%0d got=%0d exp=%0d", i, pulsewidth, pw_m);
            else n_pass++;
            n_total++;
            if (at_target !== last) $display("FAIL ramp_at_target idx=%0d got=%b exp=%b", i, at_target, last);
            else n_pass++;
            n_total++;
            if (cmd_ready !== last) $display("FAIL ramp_ready idx=%0d got=%b exp=%b", i, cmd_ready, last);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        n_total++;
        if (pulsewidth !== 12'(CENTER)) $display("FAIL reset_pw got=%0d exp=%0d", pulsewidth, CENTER);
        else n_pass++;
        n_total++;
        if (at_target !== 1'b1) $display("FAIL reset_at_target got=%b exp=1", at_target);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err);
        else n_pass++;
        rst = 1'b0;
        wait_tick(n);
        n_total++;
        if (n !== PERIOD - 1) $display("FAIL first_tick_cycles got=%0d exp=%0d", n, PERIOD - 1);
        else n_pass++;
        wait_tick(n);
        n_total++;
        if (n !== PERIOD) $display("FAIL tick_spacing got=%0d exp=%0d", n, PERIOD);
        else n_pass++;
    endtask

    task automatic test_no_move();
        do_cmd(50, 1'b0);
    endtask

    task automatic test_ramp_up();
        do_cmd(100, 1'b0);
    endtask

    task automatic test_ramp_down();
        do_cmd(3, 1'b0);
    endtask

    task automatic test_random();
        int pos;
        for (int i = 0; i < 4; i++) begin
            pos = pw_m - MIN_PW + int'($urandom_range(0, 10)) - 5;
            if (pos < 0) pos = 0;
            if (pos > PW_RANGE) pos = PW_RANGE;
            do_cmd(pos, (i % 2) == 1);
        end
    endtask

    task automatic test_en_hold_and_rst();
        int n;
        apply_reset();
        @(negedge clk);
        cmd_pos   = 8'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        wait_tick(n);
        @(negedge clk);
        pw_m = CENTER - STEP;
        n_total++;
        if (pulsewidth !== 12'(pw_m)) $display("FAIL hold_first_step got=%0d exp=%0d", pulsewidth, pw_m);
        else n_pass++;
        en = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            n_total++;
            if (pulsewidth !== 12'(pw_m) || cmd_ready !== 1'b0)
                $display("FAIL en_low_hold pw=%0d exp=%0d ready=%b exp=0", pulsewidth, pw_m, cmd_ready);
            else
                n_pass++;
        end
        en = 1'b1;
        wait_tick(n);
        @(negedge clk);
        pw_m = CENTER - 2 * STEP;
        n_total++;
        if (pulsewidth !== 12'(pw_m)) $display("FAIL resume_step got=%0d exp=%0d", pulsewidth, pw_m);
        else n_pass++;
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (pulsewidth !== 12'(CENTER)) $display("FAIL rst_mid_ramp_pw got=%0d exp=%0d", pulsewidth, CENTER);
        else n_pass++;
        n_total++;
        if (at_target !== 1'b1) $display("FAIL rst_mid_ramp_at_target got=%b exp=1", at_target);
        else n_pass++;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        pw_m  = CENTER;
        err_m = 1'b0;
    endtask

    task automatic test_range_err();
        @(negedge clk);
        cmd_pos   = 8'd250;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (err !== ERR_ON) $display("FAIL range_err got=%b exp=%b", err, ERR_ON);
        else n_pass++;
        n_total++;
        if (at_target !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL range_moving at_target=%b ready=%b exp=0/0", at_target, cmd_ready);
        else
            n_pass++;
        apply_reset();
        @(negedge clk);
        n_total++;
        if (err !== 1'b0) $display("FAIL err_cleared got=%b exp=0", err);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        cmd_valid = 1'b0;
        cmd_pos   = 8'd0;
        test_reset();
        test_no_move();
        test_ramp_up();
        test_ramp_down();
        test_random();
        test_en_hold_and_rst();
        test_range_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/servo_slew_ctrl.md
Name: servo_slew_ctrl

Overview:
Command-side stage that feeds the pwm block's pulsewidth input. Accepts servo position commands over a valid/ready handshake and maps each to a target pulsewidth in 10 us clock units. Ramps the output pulsewidth toward the target by a bounded step once per 20 ms PWM frame, so the servo never jumps. Runs on the same 100 kHz pwm_clk domain as pwm.

Parameters:
PERIOD, 2000, frame length in clk cycles; matches the period driven into pwm.
MIN_PW, 100, pulsewidth at position 0 (1.0 ms).
PW_RANGE, 100, maximum legal position; MIN_PW+PW_RANGE = 200 (2.0 ms).
STEP, 5, maximum pulsewidth change per frame.

Ports:
clk  in  1  pwm_clk, 100 kHz
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes the block
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_pos  in  8  requested position, 0..PW_RANGE
pulsewidth  out  12  to pwm.pulsewidth
frame_tick  out  1  one-cycle pulse on the last cycle of each frame
at_target  out  1  pulsewidth equals the latched target
err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset values: pulsewidth = MIN_PW + PW_RANGE/2 (150). Target is the same value. FSM in IDLE, frame counter 0, cmd_ready=1, at_target=1, frame_tick=0, err=0.
- Frame counter: increments 0..PERIOD-1 while en=1, then wraps to 0. frame_tick=1 when count==PERIOD-1 and en=1.
- FSM states:
  - IDLE: cmd_ready=en. A handshake (cmd_valid & cmd_ready) in cycle N latches target = MIN_PW + min(cmd_pos, PW_RANGE) at N+1.
    - If the new target equals pulsewidth, stay in IDLE.
    - Otherwise move to MOVING at N+1, with at_target=0 from N+1.
  - MOVING: cmd_ready=0; cmd_valid is ignored, so the command source must hold it. On each frame_tick:
    - if |target - pulsewidth| <= STEP, set pulsewidth = target, go to IDLE, at_target=1 (same edge);
    - else move pulsewidth STEP toward target.
    - Pulsewidth changes only on the frame_tick edge, so pwm sees at most one change per frame.
- Handshake coinciding with frame_tick in IDLE: no step that tick. The first step occurs at the next frame_tick, i.e. latency to first change is 1..PERIOD+1 cycles.
- Arithmetic: 12-bit unsigned throughout. Compute the difference as target >= pulsewidth ? target - pulsewidth : pulsewidth - target. No underflow is possible because pulsewidth stays within [MIN_PW, MIN_PW+PW_RANGE].
- en=0: counter, FSM, target and pulsewidth hold; cmd_ready=0; frame_tick=0. Resumes exactly where it stopped when en returns to 1.
- rst asserted mid-ramp: immediate return to the reset values, with pulsewidth jumping to center.

Optional Feature:
SERVO_SLEW_CTRL_RANGE_ERR_EN.
- Defined: a handshake with cmd_pos > PW_RANGE still clamps the target, and also sets err=1. err stays set until rst.
- Undefined: out-of-range commands are silently clamped and err is tied to 0.

Decomposition:
- Package servo_pkg holds:
  - PW_W = 12;
  - default PERIOD/MIN_PW/PW_RANGE/STEP constants;
  - FSM state enum {IDLE, MOVING}.
- Sub-module servo_frame_timer (counter plus frame_tick, with en) is natural. It can later drive pwm's frame alignment.

Test Plan:
1. Reset, then release with en=1 -> pulsewidth=150, at_target=1, cmd_ready=1; frame_tick every 2000 cycles (20 ms).
2. Command cmd_pos=100 -> cmd_ready drops the next cycle; pulsewidth goes 155, 160 ... 200 on 10 successive frame_ticks; at_target=1 and cmd_ready=1 on the 10th tick.
3. From 200, command cmd_pos=3 (target 103) -> 19 steps of -5 to 105, then a final step to 103 on the 20th tick.
4. Command cmd_pos=50 while pulsewidth=150 -> no MOVING; cmd_ready stays 1 and pulsewidth is unchanged.
5. Mid-ramp: drop en for 5000 cycles -> no ticks and pulsewidth held. Then assert rst mid-ramp -> pulsewidth=150 immediately.
6. cmd_pos=250 -> target 200. err=1 with SERVO_SLEW_CTRL_RANGE_ERR_EN defined, err=0 without it.
